// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiters.
// The picker works on a fixed 8-bit request vector so that one function covers every N up to 8.
package wb_arb_pkg;
    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;
    localparam int SEL_W  = 4;
    localparam int TGD_W  = 4;
    localparam int MAX_M  = 8;
    localparam int MAX_IW = 3;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_e;

    typedef struct packed {
        logic              valid;
        logic [MAX_IW-1:0] idx;
    } rr_pick_t;

    // Returns the first requester at or after ptr, searching upward modulo n.
    // The scan runs from the far end downward, so the nearest requester is the last one written.
    function automatic rr_pick_t rr_pick(input logic [MAX_M-1:0] req,
                                         input logic [MAX_IW-1:0] ptr,
                                         input int n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = MAX_M - 1; k >= 0; k--) begin
            if (k < n) begin
                j = (int'(ptr) + k) % n;
                if (req[j]) begin
                    res.valid = 1'b1;
                    res.idx   = MAX_IW'(j);
                end
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle shared by masters, the arbiter and the RAM wrapper.
interface wb_bus_t;
    import wb_arb_pkg::*;

    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_dat_ms;
    logic [SEL_W-1:0] wb_sel;
    logic [DAT_W-1:0] wb_dat_sm;
    logic [TGD_W-1:0] wb_tgd_sm;
    logic             wb_ack;
    logic             wb_err;
    logic             wb_rty;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
        input  wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
        output wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/wb_rr_arbiter_rr_priority_sel.sv
// Combinational round-robin picker; shared with the peripheral-bus arbiters.
module rr_priority_sel
    import wb_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    logic [MAX_M-1:0] req_ext;
    rr_pick_t         pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_pick(req_ext, MAX_IW'(ptr), N);
        valid          = pick.valid;
        idx            = pick.idx[IW-1:0];
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between N_MASTERS masters.
// Grant is held until the master drops cyc; a watchdog aborts stalled strobes with err.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_i,
    wb_bus_t.slave               wb_m [N_MASTERS],
    wb_bus_t.master              wb_s,
    output logic [N_MASTERS-1:0] gnt_o
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTERS - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

    arb_state_e    state_reg, state_next;
    logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [WW-1:0] wd_cnt_reg, wd_cnt_next;
    logic          err_sent_reg, err_sent_next;

    logic [N_MASTERS-1:0] cyc_m, stb_m, we_m;
    logic [ADR_W-1:0]     adr_m [N_MASTERS];
    logic [DAT_W-1:0]     dat_m [N_MASTERS];
    logic [SEL_W-1:0]     sel_m [N_MASTERS];

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] rel_ptr;
    logic          busy, abort, g_cyc, g_stb, s_term;

    assign busy    = (state_reg == BUSY);
    assign abort   = (state_reg == ABORT);
    assign g_cyc   = cyc_m[gnt_idx_reg];
    assign g_stb   = stb_m[gnt_idx_reg];
    assign s_term  = wb_s.wb_ack | wb_s.wb_err | wb_s.wb_rty;
    assign rel_ptr = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            logic sel_me;
            assign sel_me    = (gnt_idx_reg == IW'(gi));
            assign cyc_m[gi] = wb_m[gi].wb_cyc;
            assign stb_m[gi] = wb_m[gi].wb_stb;
            assign we_m[gi]  = wb_m[gi].wb_we;
            assign adr_m[gi] = wb_m[gi].wb_adr;
            assign dat_m[gi] = wb_m[gi].wb_dat_ms;
            assign sel_m[gi] = wb_m[gi].wb_sel;

            // Responses reach only the granted master; in ABORT it gets a single err pulse.
            assign wb_m[gi].wb_ack    = (busy && sel_me) ? wb_s.wb_ack : 1'b0;
            assign wb_m[gi].wb_rty    = (busy && sel_me) ? wb_s.wb_rty : 1'b0;
            assign wb_m[gi].wb_err    = sel_me && ((busy && wb_s.wb_err) || (abort && !err_sent_reg));
            assign wb_m[gi].wb_dat_sm = (busy && sel_me) ? wb_s.wb_dat_sm : '0;
            assign wb_m[gi].wb_tgd_sm = (busy && sel_me) ? wb_s.wb_tgd_sm : '0;
            assign gnt_o[gi]          = (busy || abort) && sel_me;
        end
    endgenerate

    assign wb_s.wb_cyc    = busy && g_cyc;
    assign wb_s.wb_stb    = busy && g_stb;
    assign wb_s.wb_we     = busy && we_m[gnt_idx_reg];
    assign wb_s.wb_adr    = busy ? adr_m[gnt_idx_reg] : '0;
    assign wb_s.wb_dat_ms = busy ? dat_m[gnt_idx_reg] : '0;
    assign wb_s.wb_sel    = busy ? sel_m[gnt_idx_reg] : '0;

    rr_priority_sel #(.N(N_MASTERS)) u_pick (
        .req   (cyc_m),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next    = state_reg;
        gnt_idx_next  = gnt_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        wd_cnt_next   = '0;
        err_sent_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_next = pick_idx;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_next  = IDLE;
                    rr_ptr_next = rel_ptr;
                end else if (g_stb && !s_term) begin
                    if (wd_cnt_reg >= WD_LIMIT) begin
                        state_next  = ABORT;
                        wd_cnt_next = wd_cnt_reg;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + 1'b1;
                    end
                end
            end
            ABORT: begin
                err_sent_next = 1'b1;
                if (!g_cyc) begin
                    state_next  = IDLE;
                    rr_ptr_next = rel_ptr;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            gnt_idx_reg  <= '0;
            rr_ptr_reg   <= '0;
            wd_cnt_reg   <= '0;
            err_sent_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_idx_reg  <= gnt_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
            wd_cnt_reg   <= wd_cnt_next;
            err_sent_reg <= err_sent_next;
        end
    end
endmodule
